uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

UART transmit framer and serializer for the UART TX path, directly downstream of the parity calculator. It accepts one parallel data word per frame and shifts it out LSB-first on a single line. A frame is a start bit, WIDTH data bits, an optional parity bit and a stop bit. The parity bit is taken from the upstream parity stage, which is driven by the same data_in/data_valid_in pair. Each bit is held for a runtime-programmable number of clk cycles.

## Interface
- WIDTH, 8, data word width in bits.
- clk  in  1  transmit clock; all state updates on the rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- data_in  in  WIDTH  word to transmit; sampled only on acceptance.
- data_valid_in  in  1  single-cycle request to transmit data_in.
- par_en_in  in  1  1 = insert parity bit; sampled on acceptance.
- par_bit_in  in  1  parity bit from the parity stage; valid from the cycle after acceptance; sampled on entry to PARITY.
- prescale_in  in  6  clk cycles per bit; sampled on acceptance; value 0 is treated as 1.
- tx_out  out  1  serial line; idle high.
- busy_out  out  1  high while a frame is in progress (START through last STOP cycle).

## Operation
- FSM states:
  - IDLE: tx_out=1, busy_out=0.
  - START: tx_out=0.
  - DATA: tx_out=shift_reg[0].
  - PARITY: tx_out=latched parity.
  - STOP: tx_out=1.
  - STOP2: tx_out=1; present only with the macro.
- Acceptance: in IDLE with data_valid_in=1, the block latches data_in into the shift register, latches par_en_in and prescale_in (0 becomes 1), and goes to START.
- data_valid_in outside IDLE is ignored; the word is dropped and no state changes. Upstream must check busy_out.
- Bit counter:
  - Runs 0..P-1 within each bit, where P is the latched prescale.
  - On reaching P-1, the bit ends and the counter clears.
- Transitions at bit end:
  - START -> DATA.
  - DATA: shift right by one; after WIDTH data bits, go to PARITY if parity is enabled, else STOP.
  - PARITY -> STOP.
  - STOP -> IDLE, or STOP2 when compiled in; STOP2 -> IDLE.
- Data-bit index counter width is clog2(WIDTH+1); the shift register is WIDTH bits.
- tx_out and busy_out are registered outputs; no combinational path from inputs.

## Timing
- Reset values: tx_out=1, busy_out=0, state IDLE, all counters 0.
- Reset mid-frame aborts immediately (asynchronously): tx_out goes high, busy_out goes low, and the partial frame is not resumed.
- Acceptance at edge N: tx_out=0 and busy_out=1 from cycle N+1.
- Frame length is (1 + WIDTH + par_en + NSTOP) × P cycles, where NSTOP is 1, or 2 with the macro. busy_out is high for exactly that many cycles.
- After the final stop cycle, the block spends at least one IDLE cycle (tx_out=1, busy_out=0) before the next start bit.
  - Back-to-back: data_valid_in asserted in that IDLE cycle starts the next frame on the following cycle.
- par_bit_in may change freely except in the cycle the FSM enters PARITY.
- Changes to prescale_in or par_en_in mid-frame have no effect until the next acceptance.

## Configuration
- UART_TX_TWO_STOP_EN:
  - Defined: STOP2 is compiled in, and every frame ends with two stop bits, each P cycles.
  - Undefined: the STOP2 state and its logic are absent, and there is one stop bit.
- Runtime ports are identical in both builds.

## Test plan
- WIDTH=8, prescale_in=1, data_in=0xA5, par_en_in=1, par_bit_in=0.
  - Required tx_out from cycle N+1: 0,1,0,1,0,0,1,0,1,0,1, then idle 1.
  - busy_out high for exactly 11 cycles.
- prescale_in=4, data_in=0x3C, par_en_in=0.
  - Each bit is held 4 cycles: start 0, data 0,0,1,1,1,1,0,0, stop 1.
  - busy_out high for 40 cycles.
- Drop while busy: during the frame of 0x3C, pulse data_valid_in with 0xFF.
  - The 0x3C frame completes unchanged.
  - No second frame follows; tx_out stays 1.
- Reset mid-frame: assert reset_n=0 during the 4th data bit.
  - tx_out=1 and busy_out=0 immediately.
  - After release, line idle until new data_valid_in.
- Back-to-back: assert data_valid_in with 0x01 in the first IDLE cycle after a 0x80 frame.
  - Exactly one idle-high cycle between the stop bit and the next start bit.
- With UART_TX_TWO_STOP_EN, prescale_in=1, 0xA5, par_en_in=1.
  - Frame is 12 cycles, ending in 1,1; busy_out high for 12 cycles.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmit framer/serializer: start bit, WIDTH data bits LSB-first,
// optional parity bit, stop bit(s). Each bit is held for a latched prescale.
// Build option: define UART_TX_TWO_STOP_EN for a second stop bit (STOP2).
module uart_tx_frame #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid_in,
  input  logic             par_en_in,
  input  logic             par_bit_in,
  input  logic [5:0]       prescale_in,
  output logic             tx_out,
  output logic             busy_out
);

  localparam int unsigned IDX_W = $clog2(WIDTH + 1);
  localparam int unsigned PRE_W = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
`ifdef UART_TX_TWO_STOP_EN
    , S_STOP2
`endif
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   shift_reg;
  logic [WIDTH-1:0]   shift_nxt;
  logic [IDX_W-1:0]   bit_idx;
  logic [PRE_W-1:0]   cnt;
  logic [PRE_W-1:0]   prescale_q;
  logic               par_en_q;
  logic               bit_end;

  // Next shift-register contents and end-of-bit strobe.
  assign shift_nxt = shift_reg >> 1;
  assign bit_end   = (cnt == PRE_W'(prescale_q - PRE_W'(1)));

  // Frame FSM with registered line and busy outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      shift_reg  <= '0;
      bit_idx    <= '0;
      cnt        <= '0;
      prescale_q <= '0;
      par_en_q   <= 1'b0;
      tx_out     <= 1'b1;
      busy_out   <= 1'b0;
    end else begin
      if (state != S_IDLE) begin
        if (bit_end) cnt <= '0;
        else         cnt <= cnt + PRE_W'(1);
      end

      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (data_valid_in) begin
            shift_reg  <= data_in;
            par_en_q   <= par_en_in;
            prescale_q <= (prescale_in == '0) ? PRE_W'(1) : prescale_in;
            bit_idx    <= '0;
            tx_out     <= 1'b0;
            busy_out   <= 1'b1;
            state      <= S_START;
          end
        end

        S_START: begin
          if (bit_end) begin
            tx_out <= shift_reg[0];
            state  <= S_DATA;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            bit_idx <= bit_idx + IDX_W'(1);
            if (bit_idx == IDX_W'(WIDTH - 1)) begin
              if (par_en_q) begin
                tx_out <= par_bit_in;
                state  <= S_PARITY;
              end else begin
                tx_out <= 1'b1;
                state  <= S_STOP;
              end
            end else begin
              shift_reg <= shift_nxt;
              tx_out    <= shift_nxt[0];
            end
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            tx_out <= 1'b1;
            state  <= S_STOP;
          end
        end

        S_STOP: begin
          if (bit_end) begin
`ifdef UART_TX_TWO_STOP_EN
            state    <= S_STOP2;
`else
            busy_out <= 1'b0;
            state    <= S_IDLE;
`endif
          end
        end

`ifdef UART_TX_TWO_STOP_EN
        S_STOP2: begin
          if (bit_end) begin
            busy_out <= 1'b0;
            state    <= S_IDLE;
          end
        end
`endif

        default: begin
          tx_out   <= 1'b1;
          busy_out <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: frame shape, prescale, parity, drop while
// busy, asynchronous reset mid-frame, back-to-back frames, prescale 0.
module tb_uart_tx_frame;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] data_in;
  logic             data_valid_in;
  logic             par_en_in;
  logic             par_bit_in;
  logic [5:0]       prescale_in;
  logic             tx_out;
  logic             busy_out;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_frame #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .data_in       (data_in),
    .data_valid_in (data_valid_in),
    .par_en_in     (par_en_in),
    .par_bit_in    (par_bit_in),
    .prescale_in   (prescale_in),
    .tx_out        (tx_out),
    .busy_out      (busy_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Line must be idle ({busy,tx} = 01) for n cycles.
  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s[%0d]", tag, i), 32'({busy_out, tx_out}), 32'h1);
      @(negedge clk);
    end
  endtask

  // Launch one frame at a falling edge and check every cycle of it plus the
  // first idle cycle. drop_at >= 0 pulses a competing request at that cycle.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic pe,
                           input logic pb, input logic [5:0] ps, input int drop_at);
    bit bits[$];
    int p;
    int total;
    p = (ps == 6'd0) ? 1 : int'(ps);
    bits.push_back(1'b0);
    for (int k = 0; k < WIDTH; k++) bits.push_back(d[k]);
    if (pe) bits.push_back(pb);
    bits.push_back(1'b1);
`ifdef UART_TX_TWO_STOP_EN
    bits.push_back(1'b1);
`endif
    total = bits.size() * p;

    data_in       = d;
    par_en_in     = pe;
    par_bit_in    = pb;
    prescale_in   = ps;
    data_valid_in = 1'b1;
    @(negedge clk);
    data_valid_in = 1'b0;

    for (int i = 0; i < total; i++) begin
      check($sformatf("%s[%0d]", tag, i), 32'({busy_out, tx_out}), 32'({1'b1, bits[i / p]}));
      if (i == drop_at) begin
        data_in       = 8'hFF;
        prescale_in   = 6'd1;
        par_en_in     = 1'b1;
        data_valid_in = 1'b1;
      end else if (i == drop_at + 1) begin
        data_valid_in = 1'b0;
      end
      @(negedge clk);
    end
    check($sformatf("%s_idle", tag), 32'({busy_out, tx_out}), 32'h1);
  endtask

  initial begin
    reset_n       = 1'b0;
    data_in       = '0;
    data_valid_in = 1'b0;
    par_en_in     = 1'b0;
    par_bit_in    = 1'b0;
    prescale_in   = 6'd1;

    #12;
    check("reset_tx", 32'(tx_out), 32'h1);
    check("reset_busy", 32'(busy_out), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    idle_check("post_reset", 2);

    // 0xA5, P=1, parity 0: 0,1,0,1,0,0,1,0,1,0,1
    run_frame("f_a5", 8'hA5, 1'b1, 1'b0, 6'd1, -1);
    idle_check("idle_a5", 3);

    // Parity bit 1 with P=2.
    run_frame("f_0f", 8'h0F, 1'b1, 1'b1, 6'd2, -1);
    idle_check("idle_0f", 2);

    // 0x3C, P=4, no parity; competing request mid-frame must be dropped.
    run_frame("f_3c", 8'h3C, 1'b0, 1'b0, 6'd4, 10);
    idle_check("no_second", 12);

    // Reset during the 4th data bit (a 0 bit of 0x34) with P=2.
    data_in       = 8'h34;
    par_en_in     = 1'b0;
    prescale_in   = 6'd2;
    data_valid_in = 1'b1;
    @(negedge clk);
    data_valid_in = 1'b0;
    for (int i = 0; i < 8; i++) @(negedge clk);
    check("rst_pre_tx", 32'({busy_out, tx_out}), 32'h2);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_tx", 32'(tx_out), 32'h1);
    check("rst_async_busy", 32'(busy_out), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    idle_check("rst_idle", 6);

    // Back-to-back: exactly one idle cycle between frames.
    run_frame("f_80", 8'h80, 1'b0, 1'b0, 6'd1, -1);
    run_frame("f_01", 8'h01, 1'b0, 1'b0, 6'd1, -1);
    idle_check("idle_b2b", 2);

    // Prescale 0 behaves as 1.
    run_frame("f_c3_p0", 8'hC3, 1'b1, 1'b1, 6'd0, -1);
    idle_check("idle_end", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety net in case the run stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
